// File: rtl/minesweeper_pkg.sv
// ---------------------------------------------------------------------------
// minesweeper_pkg
//   Shared definitions for the minesweeper board pipeline: default board
//   geometry, the cell marker used for mines, coordinate types for the
//   default board, the mine placer FSM state encoding and the LFSR step
//   function used to generate candidate cells.
// ---------------------------------------------------------------------------
package minesweeper_pkg;

  localparam int BOARD_W           = 8;
  localparam int BOARD_H           = 8;
  localparam int DEFAULT_NUM_MINES = 10;
  localparam int CELL_W            = 4;

  localparam logic [CELL_W-1:0] DEFAULT_MINE_VALUE = 4'hF;

  // Galois feedback taps for a maximal-length 16-bit sequence, and the value
  // that replaces an all-zero seed (zero is the one state the LFSR never leaves).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef logic [$clog2(BOARD_W)-1:0] coord_x_t;
  typedef logic [$clog2(BOARD_H)-1:0] coord_y_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_INC,
    ST_MARK,
    ST_DONE
  } place_state_t;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Galois LFSR. It advances on every clock except the
//   cycle in which a seed is loaded. A zero seed is replaced by the default
//   seed so the register can never lock up.
//
//   clk    in   clock
//   reset  in   asynchronous active-high reset, register returns to default seed
//   load   in   load seed this cycle instead of advancing
//   seed   in   16-bit seed value
//   value  out  current LFSR contents
// ---------------------------------------------------------------------------
module lfsr16
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = lfsr_advance(value_q);
    if (load) begin
      value_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= LFSR_DEFAULT_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mine_placer.sv
// ---------------------------------------------------------------------------
// mine_placer
//   Places NUM_MINES mines on distinct pseudo-random cells of a cleared board,
//   never on the safe (first-clicked) cell. Each accepted mine produces one
//   inc_adjacent strobe so the board builds its neighbour counts; once all
//   mines are placed the occupancy bitmap is scanned in raster order and
//   every mine cell gets one write_en strobe carrying the mine marker. Since
//   all marks follow all increments, mine cells end at MINE_VALUE and every
//   other cell holds its exact neighbour count.
//
//   clk          in   clock
//   reset        in   asynchronous active-high reset, aborts any placement
//   start        in   begin placement (accepted only in IDLE)
//   safe_x/y     in   cell that must stay mine-free, latched on start
//   seed_load    in   load seed into the LFSR (IDLE only)
//   seed         in   LFSR seed, zero is replaced by 16'hACE1
//   busy         out  placement in progress
//   done         out  one-cycle completion pulse
//   write_en     out  board write strobe (mine marker)
//   inc_adjacent out  board neighbour-increment strobe
//   write_x/y    out  board cell coordinate for either strobe
//   write_value  out  always MINE_VALUE
// ---------------------------------------------------------------------------
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int                   WIDTH      = BOARD_W,
  parameter int                   HEIGHT     = BOARD_H,
  parameter int                   NUM_MINES  = DEFAULT_NUM_MINES,
  parameter int                   BUS_WIDTH  = CELL_W,
  parameter logic [BUS_WIDTH-1:0] MINE_VALUE = BUS_WIDTH'(DEFAULT_MINE_VALUE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(WIDTH)-1:0]  safe_x,
  input  logic [$clog2(HEIGHT)-1:0] safe_y,
  input  logic                      seed_load,
  input  logic [15:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      write_en,
  output logic                      inc_adjacent,
  output logic [$clog2(WIDTH)-1:0]  write_x,
  output logic [$clog2(HEIGHT)-1:0] write_y,
  output logic [BUS_WIDTH-1:0]      write_value
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IW    = $clog2(CELLS);
  localparam int PW    = 1 << IW;
  localparam int CW    = $clog2(NUM_MINES + 1);

  if (WIDTH < 2 || HEIGHT < 2) begin : g_bad_size
    $error("mine_placer: WIDTH and HEIGHT must both be at least 2");
  end
  if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_mines
    $error("mine_placer: NUM_MINES must lie in 1 .. WIDTH*HEIGHT-1");
  end
  if (BUS_WIDTH < 4) begin : g_bad_bus
    $error("mine_placer: BUS_WIDTH must be able to hold a neighbour count of 8");
  end
  if (XW + YW > 16) begin : g_bad_coord
    $error("mine_placer: candidate coordinates do not fit in the 16-bit LFSR");
  end

  place_state_t          state_q, state_d;
  logic [CELLS-1:0]      bitmap_q, bitmap_d;
  logic [CW-1:0]         count_q, count_d;
  logic [XW-1:0]         safe_x_q, safe_x_d;
  logic [YW-1:0]         safe_y_q, safe_y_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  write_en_q, write_en_d;
  logic                  inc_q, inc_d;
  logic [XW-1:0]         write_x_q, write_x_d;
  logic [YW-1:0]         write_y_q, write_y_d;
  logic [BUS_WIDTH-1:0]  write_value_q;

  logic [15:0]   lfsr_value;
  logic          lfsr_unused;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic [IW-1:0] cand_idx;
  logic [PW-1:0] bitmap_pad;
  logic [PW-1:0] cand_onehot;
  logic          cand_ok;

  // Seeds are only accepted while idle so a running placement can never be
  // perturbed from outside.
  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (seed_load && (state_q == ST_IDLE)),
    .seed  (seed),
    .value (lfsr_value)
  );

  // Only the low coordinate bits select a candidate; the rest of the state
  // just keeps the sequence long.
  assign lfsr_unused = ^lfsr_value;
  assign cand_x      = lfsr_value[XW-1:0];
  assign cand_y      = lfsr_value[XW+YW-1:XW];
  assign cand_idx    = IW'(cand_y) * IW'(WIDTH) + IW'(cand_x);

  // The bitmap is padded to a power of two so an out-of-board candidate index
  // still reads a defined (zero) bit; such candidates are rejected anyway.
  assign bitmap_pad  = PW'(bitmap_q);
  assign cand_onehot = PW'(1) << cand_idx;

  assign cand_ok = (int'(cand_x) < WIDTH) &&
                   (int'(cand_y) < HEIGHT) &&
                   !((cand_x == safe_x_q) && (cand_y == safe_y_q)) &&
                   !bitmap_pad[cand_idx];

  // Next-state logic. Strobes are computed one cycle ahead so every output
  // comes straight from a flop: the cycle spent in INC carries inc_adjacent,
  // and MARK cycle k carries the write for bitmap index k.
  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    count_d    = count_q;
    safe_x_d   = safe_x_q;
    safe_y_d   = safe_y_q;
    scan_idx_d = scan_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    write_en_d = 1'b0;
    inc_d      = 1'b0;
    write_x_d  = write_x_q;
    write_y_d  = write_y_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_PICK;
          busy_d   = 1'b1;
          bitmap_d = '0;
          count_d  = '0;
          safe_x_d = safe_x;
          safe_y_d = safe_y;
        end
      end

      ST_PICK: begin
        if (cand_ok) begin
          bitmap_d  = bitmap_q | CELLS'(cand_onehot);
          write_x_d = cand_x;
          write_y_d = cand_y;
          inc_d     = 1'b1;
          state_d   = ST_INC;
        end
      end

      ST_INC: begin
        count_d = count_q + CW'(1);
        if (count_d == CW'(NUM_MINES)) begin
          state_d    = ST_MARK;
          scan_idx_d = '0;
          write_en_d = bitmap_q[0];
          write_x_d  = '0;
          write_y_d  = '0;
        end else begin
          state_d = ST_PICK;
        end
      end

      ST_MARK: begin
        if (scan_idx_q == IW'(CELLS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          // write_x/write_y already hold the current scan cell, so they double
          // as the raster counters for the next one.
          scan_idx_d = scan_idx_q + IW'(1);
          write_en_d = bitmap_pad[scan_idx_q + IW'(1)];
          if (write_x_q == XW'(WIDTH - 1)) begin
            write_x_d = '0;
            write_y_d = write_y_q + YW'(1);
          end else begin
            write_x_d = write_x_q + XW'(1);
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and every output register; reset abandons any placement at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitmap_q      <= '0;
      count_q       <= '0;
      safe_x_q      <= '0;
      safe_y_q      <= '0;
      scan_idx_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      write_en_q    <= 1'b0;
      inc_q         <= 1'b0;
      write_x_q     <= '0;
      write_y_q     <= '0;
      write_value_q <= MINE_VALUE;
    end else begin
      state_q       <= state_d;
      bitmap_q      <= bitmap_d;
      count_q       <= count_d;
      safe_x_q      <= safe_x_d;
      safe_y_q      <= safe_y_d;
      scan_idx_q    <= scan_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      write_en_q    <= write_en_d;
      inc_q         <= inc_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_value_q <= MINE_VALUE;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign write_en     = write_en_q;
  assign inc_adjacent = inc_q;
  assign write_x      = write_x_q;
  assign write_y      = write_y_q;
  assign write_value  = write_value_q;

endmodule

// File: tb/tb_mine_placer.sv
// ---------------------------------------------------------------------------
// tb_mine_placer
//   Two placers: an 8x8 board with 10 mines and a 5x6 board filled with 29
//   mines (every cell but the safe one). Each run pushes the expected strobe
//   sequence into a per-board queue; a negedge monitor pops and compares on
//   every strobe, and also drives a small board model whose final contents
//   are compared against neighbour counts derived from the expected mines.
// ---------------------------------------------------------------------------
module tb_mine_placer;

  typedef enum logic [1:0] {EV_INC = 2'd0, EV_WR = 2'd1, EV_DONE = 2'd2} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] x;
    logic [7:0] y;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        seed_load;
  logic [15:0] seed;
  logic [2:0]  safe_x, safe_y;

  logic       a_busy, a_done, a_wen, a_inc;
  logic [2:0] a_wx, a_wy;
  logic [3:0] a_wv;
  logic       b_busy, b_done, b_wen, b_inc;
  logic [2:0] b_wx, b_wy;
  logic [3:0] b_wv;

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  last_inc [2];
  int  board [2][64];
  bit  ref_bm [2][64];
  bit  exp_bm [64];
  ev_t qa[$];
  ev_t qb[$];
  ev_t exp_tmp[$];

  mine_placer #(.WIDTH(8), .HEIGHT(8), .NUM_MINES(10), .BUS_WIDTH(4), .MINE_VALUE(4'hF)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .safe_x(safe_x), .safe_y(safe_y),
    .seed_load(seed_load), .seed(seed), .busy(a_busy), .done(a_done), .write_en(a_wen),
    .inc_adjacent(a_inc), .write_x(a_wx), .write_y(a_wy), .write_value(a_wv)
  );

  mine_placer #(.WIDTH(5), .HEIGHT(6), .NUM_MINES(29), .BUS_WIDTH(4), .MINE_VALUE(4'hF)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .safe_x(safe_x), .safe_y(safe_y),
    .seed_load(seed_load), .seed(seed), .busy(b_busy), .done(b_done), .write_en(b_wen),
    .inc_adjacent(b_inc), .write_x(b_wx), .write_y(b_wy), .write_value(b_wv)
  );

  // Free-running clock and a cycle counter used for phase-length checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something escapes every bounded wait
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference placement: one candidate per PICK cycle, the INC cycle skips one
  // LFSR value, then raster-order marks and a final done.
  task automatic build_expect(input int w, input int h, input int n, input int xw, input int yw,
                              input logic [15:0] sd, input int sx, input int sy);
    logic [15:0] v;
    int cx, cy, cnt, guard;
    ev_t e;
    exp_tmp.delete();
    for (int i = 0; i < 64; i++) exp_bm[i] = 1'b0;
    v = (sd == 16'h0000) ? 16'hACE1 : sd;
    v = lfsr_step(v);
    cnt = 0;
    guard = 0;
    while (cnt < n && guard < 60000) begin
      guard++;
      cx = int'(v) & ((1 << xw) - 1);
      cy = (int'(v) >> xw) & ((1 << yw) - 1);
      if (cx < w && cy < h && !(cx == sx && cy == sy) && !exp_bm[cy*w+cx]) begin
        exp_bm[cy*w+cx] = 1'b1;
        e.kind = EV_INC; e.x = 8'(cx); e.y = 8'(cy);
        exp_tmp.push_back(e);
        cnt++;
        v = lfsr_step(lfsr_step(v));
      end else begin
        v = lfsr_step(v);
      end
    end
    for (int i = 0; i < w*h; i++) begin
      if (exp_bm[i]) begin
        e.kind = EV_WR; e.x = 8'(i % w); e.y = 8'(i / w);
        exp_tmp.push_back(e);
      end
    end
    e.kind = EV_DONE; e.x = 8'd0; e.y = 8'd0;
    exp_tmp.push_back(e);
  endtask

  function automatic logic sel_busy(input int s);
    return (s == 1) ? b_busy : a_busy;
  endfunction

  function automatic logic sel_done(input int s);
    return (s == 1) ? b_done : a_done;
  endfunction

  // Monitor: every strobe or done pulse pops one expected event; the board
  // model follows the strobes exactly as the real board memory would.
  always @(negedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        logic m_inc, m_wen, m_done, m_busy;
        logic [2:0] mx, my;
        int w, h;
        ev_t got, e;
        m_inc  = (s == 1) ? b_inc  : a_inc;
        m_wen  = (s == 1) ? b_wen  : a_wen;
        m_done = (s == 1) ? b_done : a_done;
        m_busy = (s == 1) ? b_busy : a_busy;
        mx     = (s == 1) ? b_wx   : a_wx;
        my     = (s == 1) ? b_wy   : a_wy;
        w      = (s == 1) ? 5 : 8;
        h      = (s == 1) ? 6 : 8;
        if (m_inc || m_wen || m_done) begin
          checkOutput($sformatf("strobe_exclusive_%0d", s), 32'(m_inc && m_wen), 32'd0);
          if (s == 1 && (m_inc || m_wen)) begin
            checkOutput("b_x_in_range", 32'(int'(mx) < 5), 32'd1);
            checkOutput("b_y_in_range", 32'(int'(my) < 6), 32'd1);
          end
          got.kind = m_inc ? EV_INC : (m_wen ? EV_WR : EV_DONE);
          got.x    = (got.kind == EV_DONE) ? 8'd0 : {5'd0, mx};
          got.y    = (got.kind == EV_DONE) ? 8'd0 : {5'd0, my};
          if (((s == 1) ? qb.size() : qa.size()) == 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL unexpected_event_%0d: got %0h, expected no event", s, got);
          end else begin
            e = (s == 1) ? qb.pop_front() : qa.pop_front();
            checkOutput($sformatf("event_%0d", s), 32'(got), 32'(e));
          end
          if (m_inc) begin
            last_inc[s] = cyc;
            for (int dy = -1; dy <= 1; dy++) begin
              for (int dx = -1; dx <= 1; dx++) begin
                int nx, ny;
                nx = int'(mx) + dx;
                ny = int'(my) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < w && ny >= 0 && ny < h)
                  board[s][ny*w+nx] = (board[s][ny*w+nx] + 1) & 15;
              end
            end
          end
          if (m_wen && (int'(my)*w + int'(mx)) < 64) board[s][int'(my)*w+int'(mx)] = 15;
          if (m_done) begin
            checkOutput($sformatf("mark_length_%0d", s), 32'(cyc - last_inc[s]), 32'(w*h + 1));
            checkOutput($sformatf("busy_in_done_%0d", s), 32'(m_busy), 32'd1);
          end
        end
      end
    end
  end

  // Board contents against the expected mine set: markers on mines, exact
  // neighbour counts everywhere else.
  task automatic check_board(input int s);
    int w, h, cnt;
    w = (s == 1) ? 5 : 8;
    h = (s == 1) ? 6 : 8;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && x+dx >= 0 && x+dx < w && y+dy >= 0 && y+dy < h)
              if (ref_bm[s][(y+dy)*w+x+dx]) cnt++;
        checkOutput($sformatf("board%0d_cell_%0d_%0d", s, x, y), 32'(board[s][y*w+x]),
                    ref_bm[s][y*w+x] ? 32'd15 : 32'(cnt));
      end
    end
  endtask

  // Queue the expectation, load the seed, then start on the following cycle
  task automatic launch(input int s, input logic [15:0] sd, input int sx, input int sy);
    if (s == 1) build_expect(5, 6, 29, 3, 3, sd, sx, sy);
    else        build_expect(8, 8, 10, 3, 3, sd, sx, sy);
    foreach (exp_tmp[i]) begin
      if (s == 1) qb.push_back(exp_tmp[i]);
      else        qa.push_back(exp_tmp[i]);
    end
    for (int i = 0; i < 64; i++) begin
      ref_bm[s][i] = exp_bm[i];
      board[s][i]  = 0;
    end
    @(posedge clk); #1;
    seed      = sd;
    seed_load = 1'b1;
    safe_x    = 3'(sx);
    safe_y    = 3'(sy);
    @(posedge clk); #1;
    seed_load = 1'b0;
    if (s == 1) start_b = 1'b1;
    else        start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    checkOutput($sformatf("busy_after_start_%0d", s), 32'(sel_busy(s)), 32'd1);
  endtask

  task automatic applyStimulus(input int s, input logic [15:0] sd, input int sx, input int sy,
                               input bit pulse_busy, input bit start_in_done);
    int k;
    launch(s, sd, sx, sy);
    if (pulse_busy) begin
      repeat (4) @(posedge clk);
      #1;
      start_a   = 1'b1;
      seed_load = 1'b1;
      seed      = 16'h5A5A;
      @(posedge clk); #1;
      start_a   = 1'b0;
      seed_load = 1'b0;
    end
    k = 0;
    while (k < 20000) begin
      @(negedge clk);
      if (sel_done(s)) break;
      k++;
    end
    if (k >= 20000) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL done_timeout_%0d: got no done, expected done within 20000 cycles", s);
    end else begin
      if (start_in_done) begin
        if (s == 1) start_b = 1'b1;
        else        start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      checkOutput($sformatf("busy_after_done_%0d", s), 32'(sel_busy(s)), 32'd0);
      checkOutput($sformatf("done_single_%0d", s), 32'(sel_done(s)), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput($sformatf("still_idle_%0d", s), 32'(sel_busy(s)), 32'd0);
    end
    checkOutput($sformatf("queue_drained_%0d", s), 32'((s == 1) ? qb.size() : qa.size()), 32'd0);
    check_board(s);
  endtask

  // Start a run on the 8x8 placer and hit reset during the 4th INC cycle
  task automatic reset_mid_run(input logic [15:0] sd);
    int cnt, k;
    launch(0, sd, 3, 4);
    cnt = 0;
    k = 0;
    while (cnt < 4 && k < 5000) begin
      @(negedge clk);
      if (a_inc) cnt++;
      k++;
    end
    checkOutput("fourth_inc_seen", 32'(cnt), 32'd4);
    reset = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    checkOutput("abort_busy", 32'(a_busy), 32'd0);
    checkOutput("abort_inc", 32'(a_inc), 32'd0);
    checkOutput("abort_wen", 32'(a_wen), 32'd0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort_stays_idle", 32'(a_busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    safe_x    = 3'd0;
    safe_y    = 3'd0;
    last_inc  = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_a_busy", 32'(a_busy), 32'd0);
    checkOutput("reset_a_done", 32'(a_done), 32'd0);
    checkOutput("reset_a_wen",  32'(a_wen),  32'd0);
    checkOutput("reset_a_inc",  32'(a_inc),  32'd0);
    checkOutput("reset_a_x",    32'(a_wx),   32'd0);
    checkOutput("reset_a_y",    32'(a_wy),   32'd0);
    checkOutput("reset_a_val",  32'(a_wv),   32'hF);
    checkOutput("reset_b_busy", 32'(b_busy), 32'd0);
    checkOutput("reset_b_val",  32'(b_wv),   32'hF);
    reset = 1'b0;

    $display("[TB] 8x8, 10 mines, seed 1234, safe (0,0)");
    applyStimulus(0, 16'h1234, 0, 0, 1'b0, 1'b0);

    $display("[TB] 5x6 full board, safe (4,5), start pulsed in DONE");
    applyStimulus(1, 16'hBEEF, 4, 5, 1'b0, 1'b1);
    checkOutput("b_safe_corner_count", 32'(board[1][29]), 32'd3);

    $display("[TB] reset during the 4th INC, then a fresh run");
    reset_mid_run(16'h0F0F);
    applyStimulus(0, 16'h0F0F, 3, 4, 1'b0, 1'b0);

    $display("[TB] seed 1234 again with start/seed_load pulsed while busy");
    applyStimulus(0, 16'h1234, 0, 0, 1'b1, 1'b0);

    $display("[TB] zero seed, safe (2,5)");
    applyStimulus(0, 16'h0000, 2, 5, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
